// File: rtl/cnt_pkg.sv
// cnt_pkg: constants and helpers shared by the up/down counter slice.
package cnt_pkg;

  // Direction encodings for the 'up' input
  localparam logic CNT_UP   = 1'b1;
  localparam logic CNT_DOWN = 1'b0;

  // Terminal behaviour encodings for the 'sat' input
  localparam logic CNT_WRAP = 1'b0;
  localparam logic CNT_SAT  = 1'b1;

  // A load value outside 0..modulus-1 is pinned to the top of the range,
  // so the count register can never hold an out-of-range value.
  function automatic int unsigned cnt_clamp(input int unsigned val,
                                            input int unsigned modulus);
    return (val >= modulus) ? (modulus - 1) : val;
  endfunction

endpackage

// File: rtl/cnt_prescaler.sv
// cnt_prescaler: divides enabled cycles by PRESCALE to form the count tick.
// Only instantiated when CNT_PRESCALE_EN is defined.
module cnt_prescaler #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  // A 1-bit phase register keeps PRESCALE=1 legal; it then never leaves 0
  localparam int            PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] phase;

  // The edge that completes a phase is the one that lets the counter step
  assign tick = (phase == LAST);

  // Phase advances on enabled cycles, holds otherwise; load restarts it
  always_ff @(posedge clk or posedge reset) begin
    if (reset)    phase <= '0;
    else if (clr) phase <= '0;
    else if (en)  phase <= tick ? '0 : phase + PW'(1);
  end

endmodule

// File: rtl/cnt_updown.sv
// cnt_updown: parametrised up/down counter with clamped parallel load,
// programmable modulus, wrap/saturate mode, combinational tc and a
// registered wrap pulse. Define CNT_PRESCALE_EN to gate steps through a
// PRESCALE-cycle prescaler; otherwise every enabled edge steps.
module cnt_updown
  import cnt_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int MODULUS  = 2 ** WIDTH,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pl,
  input  logic [WIDTH-1:0] in,
  input  logic             en,
  input  logic             up,
  input  logic             sat,
  output logic [WIDTH-1:0] out,
  output logic             tc,
  output logic             wrap
);

  // Reject configurations whose range cannot be represented
  generate
    if (WIDTH < 2 || MODULUS < 2 || MODULUS > (1 << WIDTH) || PRESCALE < 1) begin : g_bad_param
      $error("cnt_updown: illegal WIDTH/MODULUS/PRESCALE");
    end
  endgenerate

  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MODULUS - 1);

  logic             tick;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] nxt_out;
  logic             nxt_wrap;
  logic             at_end;

`ifdef CNT_PRESCALE_EN
  // Load wins over the step, so it also restarts the prescaler phase
  cnt_prescaler #(.PRESCALE(PRESCALE)) u_pre (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .clr   (pl),
    .tick  (tick)
  );
`else
  assign tick = 1'b1;
`endif

  assign load_val = WIDTH'(cnt_clamp(32'(in), 32'(MODULUS)));

  // Terminal value depends on the direction sampled this cycle
  assign at_end = (up == CNT_UP) ? (out == MAXV) : (out == '0);
  assign tc     = at_end;

  // Next count: load > step > hold; wrap only pulses on a wrapping step
  always_comb begin
    nxt_out  = out;
    nxt_wrap = 1'b0;
    if (pl) begin
      nxt_out = load_val;
    end else if (en && tick) begin
      if (!at_end) begin
        nxt_out = (up == CNT_UP) ? out + WIDTH'(1) : out - WIDTH'(1);
      end else if (sat == CNT_WRAP) begin
        nxt_out  = (up == CNT_UP) ? '0 : MAXV;
        nxt_wrap = 1'b1;
      end
    end
  end

  // Count and wrap registers; reset clears both without waiting for clk
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out  <= '0;
      wrap <= 1'b0;
    end else begin
      out  <= nxt_out;
      wrap <= nxt_wrap;
    end
  end

endmodule

// File: tb/tb_cnt_updown.sv
// tb_cnt_updown: scoreboard bench for cnt_updown. Three instances share the
// stimulus: MODULUS=16, MODULUS=10, and MODULUS=16 with PRESCALE=3.
module tb_cnt_updown;

`ifdef CNT_PRESCALE_EN
  localparam int PS_C = 3;
`else
  localparam int PS_C = 1;
`endif

  typedef logic [2:0][5:0] exp3_t;  // per instance: {out[3:0], wrap, tc}

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       pl = 1'b0;
  logic [3:0] in = '0;
  logic       en = 1'b0;
  logic       up = 1'b1;
  logic       sat = 1'b0;

  logic [3:0] out_a, out_b, out_c;
  logic       tc_a, tc_b, tc_c, wrap_a, wrap_b, wrap_c;
  exp3_t      obs;

  int checks = 0;
  int failures = 0;

  exp3_t q[$];
  int m_out[3], m_wrap[3], m_ph[3];
  int mod_k[3] = '{16, 10, 16};
  int ps_k[3]  = '{1, 1, PS_C};

  always #5 clk = ~clk;

  cnt_updown #(.WIDTH(4), .MODULUS(16), .PRESCALE(1)) dut_a (
    .clk(clk), .reset(reset), .pl(pl), .in(in), .en(en), .up(up), .sat(sat),
    .out(out_a), .tc(tc_a), .wrap(wrap_a));
  cnt_updown #(.WIDTH(4), .MODULUS(10), .PRESCALE(1)) dut_b (
    .clk(clk), .reset(reset), .pl(pl), .in(in), .en(en), .up(up), .sat(sat),
    .out(out_b), .tc(tc_b), .wrap(wrap_b));
  cnt_updown #(.WIDTH(4), .MODULUS(16), .PRESCALE(3)) dut_c (
    .clk(clk), .reset(reset), .pl(pl), .in(in), .en(en), .up(up), .sat(sat),
    .out(out_c), .tc(tc_c), .wrap(wrap_c));

  assign obs[0] = {out_a, wrap_a, tc_a};
  assign obs[1] = {out_b, wrap_b, tc_b};
  assign obs[2] = {out_c, wrap_c, tc_c};

  // Apply inputs for the coming edge and push what each instance should show after it
  task automatic drive(input logic r, input logic p, input logic [3:0] i,
                       input logic e, input logic u, input logic s);
    exp3_t x;
    logic  edge_hit;
    reset = r; pl = p; in = i; en = e; up = u; sat = s;
    for (int k = 0; k < 3; k++) begin
      if (r) begin
        m_out[k] = 0; m_wrap[k] = 0; m_ph[k] = 0;
      end else if (p) begin
        m_out[k] = (int'(i) >= mod_k[k]) ? mod_k[k] - 1 : int'(i);
        m_wrap[k] = 0; m_ph[k] = 0;
      end else if (e && m_ph[k] == ps_k[k] - 1) begin
        m_ph[k] = 0;
        edge_hit = u ? (m_out[k] == mod_k[k] - 1) : (m_out[k] == 0);
        if (edge_hit && s) begin
          m_wrap[k] = 0;
        end else begin
          m_wrap[k] = edge_hit ? 1 : 0;
          m_out[k] = u ? (m_out[k] + 1) % mod_k[k] : (m_out[k] + mod_k[k] - 1) % mod_k[k];
        end
      end else begin
        if (e) m_ph[k] = m_ph[k] + 1;
        m_wrap[k] = 0;
      end
      x[k] = {4'(m_out[k]), 1'(m_wrap[k]),
              u ? (m_out[k] == mod_k[k] - 1) : (m_out[k] == 0)};
    end
    q.push_back(x);
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp3_t e;
    for (int n = 0; n < 4; n++) begin
      drive(1'b1, 1'b0, 4'd0, 1'b1, (n != 3), 1'b0);
      settle();
      e = q.pop_front();
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (obs[k] !== e[k]) begin failures++; $display("FAIL reset[%0d] got=%h exp=%h", k, obs[k], e[k]); end
      end
    end
    checks++;
    if (out_a !== 4'd0 || tc_a !== 1'b1 || wrap_a !== 1'b0) begin
      failures++; $display("FAIL reset_const got out=%0d tc=%0b wrap=%0b exp out=0 tc=1 wrap=0", out_a, tc_a, wrap_a);
    end
  endtask

  task automatic test_wrap();
    exp3_t e;
    for (int n = 1; n <= 17; n++) begin
      drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0);
      settle();
      e = q.pop_front();
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (obs[k] !== e[k]) begin failures++; $display("FAIL wrap[%0d] n=%0d got=%h exp=%h", k, n, obs[k], e[k]); end
      end
      if (n == 15) begin
        checks++;
        if (out_a !== 4'd15 || tc_a !== 1'b1 || wrap_a !== 1'b0) begin
          failures++; $display("FAIL wrap_top got out=%0d tc=%0b wrap=%0b exp 15 1 0", out_a, tc_a, wrap_a);
        end
      end
      if (n == 16) begin
        checks++;
        if (out_a !== 4'd0 || wrap_a !== 1'b1) begin
          failures++; $display("FAIL wrap_pulse got out=%0d wrap=%0b exp 0 1", out_a, wrap_a);
        end
      end
    end
  endtask

  task automatic test_load();
    exp3_t e;
    logic  p;
    for (int n = 0; n < 6; n++) begin
      p = (n == 2);
      drive(1'b0, p, 4'b1010, 1'b1, 1'b1, 1'b0);
      settle();
      e = q.pop_front();
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (obs[k] !== e[k]) begin failures++; $display("FAIL load[%0d] n=%0d got=%h exp=%h", k, n, obs[k], e[k]); end
      end
      if (n >= 2) begin
        checks++;
        if (out_a !== 4'(8 + n)) begin failures++; $display("FAIL load_seq got=%0d exp=%0d", out_a, 8 + n); end
      end
    end
  endtask

  task automatic test_down_sat();
    exp3_t e;
    int    seq_b[6] = '{2, 1, 0, 0, 0, 9};
    for (int n = 0; n < 6; n++) begin
      drive(1'b0, (n == 0), 4'd2, (n != 0), 1'b0, (n != 5));
      settle();
      e = q.pop_front();
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (obs[k] !== e[k]) begin failures++; $display("FAIL down[%0d] n=%0d got=%h exp=%h", k, n, obs[k], e[k]); end
      end
      checks++;
      if (out_b !== 4'(seq_b[n]) || wrap_b !== (n == 5)) begin
        failures++; $display("FAIL down_seq n=%0d got out=%0d wrap=%0b exp out=%0d wrap=%0b", n, out_b, wrap_b, seq_b[n], (n == 5));
      end
    end
  endtask

  task automatic test_clamp();
    exp3_t e;
    for (int n = 0; n < 2; n++) begin
      drive(1'b0, (n == 0), 4'd13, (n == 1), 1'b1, 1'b0);
      settle();
      e = q.pop_front();
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (obs[k] !== e[k]) begin failures++; $display("FAIL clamp[%0d] n=%0d got=%h exp=%h", k, n, obs[k], e[k]); end
      end
    end
    checks++;
    if (out_b !== 4'd0 || wrap_b !== 1'b1) begin
      failures++; $display("FAIL clamp_wrap got out=%0d wrap=%0b exp 0 1", out_b, wrap_b);
    end
  endtask

  task automatic test_async_reset();
    exp3_t e;
    drive(1'b0, 1'b1, 4'd7, 1'b0, 1'b1, 1'b0);
    settle();
    e = q.pop_front();
    checks++;
    if (out_a !== 4'd7) begin failures++; $display("FAIL areset_pre got=%0d exp=7", out_a); end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({out_a, out_b, out_c, wrap_a, wrap_b, wrap_c} !== 15'd0) begin
      failures++; $display("FAIL areset_now got a=%0d b=%0d c=%0d w=%0b%0b%0b exp all 0", out_a, out_b, out_c, wrap_a, wrap_b, wrap_c);
    end
    for (int n = 0; n < 3; n++) begin
      drive((n == 0), 1'b0, 4'd0, 1'b1, 1'b1, 1'b0);
      settle();
      e = q.pop_front();
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (obs[k] !== e[k]) begin failures++; $display("FAIL areset[%0d] n=%0d got=%h exp=%h", k, n, obs[k], e[k]); end
      end
    end
  endtask

  task automatic test_prescale();
    exp3_t e;
    logic  p, en_n;
    for (int n = 0; n < 20; n++) begin
      p    = (n == 0) || (n == 13);
      en_n = (n != 0) && (n != 7) && (n != 8);
      drive(1'b0, p, 4'd0, en_n, 1'b1, 1'b0);
      settle();
      e = q.pop_front();
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (obs[k] !== e[k]) begin failures++; $display("FAIL prescale[%0d] n=%0d got=%h exp=%h", k, n, obs[k], e[k]); end
      end
      if (n == 3) begin
        checks++;
        if (out_c !== 4'(3 / PS_C)) begin failures++; $display("FAIL prescale_rate got=%0d exp=%0d", out_c, 3 / PS_C); end
      end
    end
  endtask

  task automatic test_back_to_back();
    exp3_t e;
    for (int n = 0; n < 300; n++) begin
      drive(($urandom_range(0, 63) == 0), ($urandom_range(0, 7) == 0), 4'($urandom_range(0, 15)),
            ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      settle();
      e = q.pop_front();
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (obs[k] !== e[k]) begin failures++; $display("FAIL random[%0d] n=%0d got=%h exp=%h", k, n, obs[k], e[k]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_wrap();
    test_load();
    test_down_sat();
    test_clamp();
    test_async_reset();
    test_prescale();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cnt_updown.md
# cnt_updown

Parametrised synchronous up/down counter with parallel load, count enable, programmable modulus, wrap/saturate mode and terminal-count flags. It is the next-generation general-purpose counter for the datapath and timing blocks. It generalises the fixed 4-bit loadable counter to arbitrary width and modulus, bidirectional counting, and an optional clock-enable prescaler.

## Interface
- `WIDTH`, 4, counter width in bits (≥ 2)
- `MODULUS`, 2**WIDTH, count range 0..MODULUS-1 (2 ≤ MODULUS ≤ 2**WIDTH)
- `PRESCALE`, 1, enabled cycles per count step (≥ 1); used only with `CNT_PRESCALE_EN`
- `clk`  in  1  clock, rising edge
- `reset`  in  1  asynchronous, active-high reset
- `pl`  in  1  parallel load strobe
- `in`  in  WIDTH  parallel load value
- `en`  in  1  count enable
- `up`  in  1  direction: 1 = increment, 0 = decrement
- `sat`  in  1  1 = saturate at the terminal value, 0 = wrap
- `out`  out  WIDTH  registered count value
- `tc`  out  1  combinational terminal-count flag
- `wrap`  out  1  registered one-cycle wrap pulse

## Operation
- Priority at each rising edge: `reset` > `pl` > step (`en` && tick) > hold.
- Reset:
  - Asynchronous, active-high; takes effect immediately, without waiting for `clk`.
  - Clears `out`, `wrap` and the prescaler to 0.
  - A reset asserted mid-count or mid-prescale discards all state.
- Load:
  - `pl`=1 loads `in` into `out` on the next edge, regardless of `en`.
  - If `in` ≥ MODULUS, the loaded value is clamped to MODULUS-1.
  - A load also clears the prescaler phase.
  - `wrap` is 0 on any load edge.
- Step up (`up`=1):
  - Below MODULUS-1: `out` += 1.
  - At MODULUS-1 with `sat`=0: `out` becomes 0 and `wrap` is 1 for that cycle.
  - At MODULUS-1 with `sat`=1: `out` holds and `wrap` stays 0.
- Step down (`up`=0):
  - Above 0: `out` -= 1.
  - At 0 with `sat`=0: `out` becomes MODULUS-1 and `wrap` is 1 for that cycle.
  - At 0 with `sat`=1: `out` holds and `wrap` stays 0.
- Flags:
  - `tc` = (`up` ? `out`==MODULUS-1 : `out`==0); it does not depend on `en`.
  - `up` and `sat` may change on any cycle; each edge uses the values sampled at that edge.
- Arithmetic: unsigned and modulo MODULUS. `out` never holds a value ≥ MODULUS.

## Timing
- Step and load latency: 1 clock. `out` shows the new value in the cycle after the qualifying edge.
- `wrap` is registered. It is high for exactly the cycle in which `out` first shows the wrapped value.
- `tc` is combinational from `out` and `up`; it carries no register delay.
- Reset values: `out`=0, `wrap`=0, `tc`=`~up` (since `out`=0).
- `pl` and `en` asserted together: the load wins, and no step or tick is consumed.

## Configuration
- Macro: `CNT_PRESCALE_EN`.
- Defined:
  - A prescaler counts edges where `en`=1 and `pl`=0.
  - tick is asserted on every PRESCALE-th such edge, and the counter steps only on edges with `en` && tick.
  - The prescaler phase holds while `en`=0 and clears on `pl` or `reset`.
  - PRESCALE=1 behaves the same as undefined.
- Undefined:
  - tick is tied to 1, and the counter steps on every edge with `en`=1.
  - The `PRESCALE` parameter exists but is ignored.

## Structure
- Shared package `cnt_pkg`:
  - Function for the clamp-to-modulus rule.
  - Direction and mode constants: `CNT_UP`, `CNT_DOWN`, `CNT_WRAP`, `CNT_SAT`.
- One sub-module, `cnt_prescaler` (ports `clk`, `reset`, `en`, `clr`, `tick`):
  - Instantiated only under `CNT_PRESCALE_EN`.
  - Holds a $clog2(PRESCALE)-bit phase register.
- Parameter legality (`MODULUS` range, `PRESCALE` ≥ 1) is checked at elaboration.

## Test plan
1. Reset and wrap, WIDTH=4, MODULUS=16: hold `reset`=1, then release with `en`=1, `up`=1, `sat`=0.
   - `out` reads 0 during reset, then steps 1, 2, … 15, 0.
   - `wrap` is high only in the cycle `out`=0 after 15.
   - `tc` is high while `out`=15.
2. Load: `pl` pulse with `in`=4'b1010 while counting. `out`=10 the next cycle, then continues 11, 12, … One-cycle latency and load-over-`en` priority are both verified.
3. Down count and saturate, MODULUS=10, `up`=0: load 2 with `sat`=1.
   - `out` reads 2, 1, 0, 0, 0, with `wrap` never asserting.
   - Then set `sat`=0: `out` goes to 9 with a `wrap` pulse.
4. Modulus clamp, MODULUS=10: load `in`=13. `out`=9 and `tc`=1 with `up`=1; the next step gives `out`=0 with `wrap`=1.
5. Asynchronous reset mid-count: assert `reset` between clock edges while `out`=7. `out`=0 before the next edge; `wrap`=0.
6. Prescaler, `CNT_PRESCALE_EN` defined, PRESCALE=3:
   - With `en`=1, `out` advances every 3 cycles.
   - Dropping `en` for 2 cycles mid-phase delays the next step by exactly 2 cycles.
   - A `pl` pulse restarts the phase, so the first step comes 3 cycles after the load.
